alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
Decode/issue stage that drives the execute-stage ALU. It accepts one MIPS instruction per cycle with its register-file operand values. It decodes the instruction into the ALU's 12-bit one-hot alu_control, selects the alu_src1 and alu_src2 operands, and produces destination register information. Results are held in a registered two-entry skid buffer with a valid/ready handshake on both sides, sitting between the ID and EX pipeline stages.

Parameters:
TAG_W, 32, width of the opaque sideband tag (PC) carried alongside each instruction unchanged.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous pipeline flush; drops all buffered entries
in_valid  input  1  upstream has an instruction
in_ready  output  1  stage can accept; equals ~skid_valid (registered, no combinational path from out_ready)
in_instr  input  32  MIPS instruction word
in_rs_value  input  32  GPR[rs]
in_rt_value  input  32  GPR[rt]
in_tag  input  TAG_W  sideband (PC)
out_valid  output  1  issued entry valid
out_ready  input  1  EX stage accepts
alu_control  output  12  one-hot: [0]add [1]sub [2]slt [3]sltu [4]and [5]nor [6]or [7]xor [8]sll [9]srl [10]sra [11]lui(pass src2)
alu_src1  output  32  ALU operand 1
alu_src2  output  32  ALU operand 2
dest  output  5  destination GPR
dest_wen  output  1  write-back enable
illegal  output  1  instruction not in the supported set
out_tag  output  TAG_W  sideband passthrough

Behaviour:
- Reset (async): main_valid=0, skid_valid=0, so out_valid=0 and in_ready=1. All payload outputs read 0.
- Decode is combinational on in_* and registered at acceptance. Outputs always come from the main register. Latency is 1 cycle (accept in cycle N, out_valid in N+1). Throughput is 1 per cycle.
- Opcode 0 (R-type), encoded as funct -> control, src1, src2:
  - 0x20/0x21 -> add, rs, rt
  - 0x22/0x23 -> sub, rs, rt
  - 0x2A -> slt; 0x2B -> sltu
  - 0x24 -> and; 0x27 -> nor; 0x25 -> or; 0x26 -> xor (all with rs, rt)
  - 0x00/0x02/0x03 -> sll/srl/sra, src1=rt_value, src2={27'b0, sa}
  - 0x04/0x06/0x07 -> sll/srl/sra, src1=rt_value, src2=rs_value (the ALU uses [4:0])
  - dest=rd
- I-type, opcode -> control, src2 (src1=rs_value, dest=rt):
  - 0x08/0x09 -> add, sext(imm)
  - 0x0A -> slt, sext(imm); 0x0B -> sltu, sext(imm)
  - 0x0C -> and, zext(imm); 0x0D -> or, zext(imm); 0x0E -> xor, zext(imm)
  - 0x0F -> lui, src2={imm, 16'b0}, src1=0
- Any other encoding: alu_control=0, illegal=1, dest_wen=0, src1/src2=0. The entry still flows through the handshake.
- dest_wen = ~illegal && (dest != 0). Instruction 0x00000000 (nop) gives sll with dest_wen=0 and illegal=0.
- Exactly one alu_control bit is set for every legal instruction.
- Handshake: accept = in_valid && in_ready; issue = out_valid && out_ready.
  - Main empty, or issue this cycle: main loads skid if skid_valid, else the accepted input. Otherwise main_valid clears.
  - Main full, no issue, and accept: the input goes to skid, and skid_valid=1 (in_ready drops next cycle).
  - Skid full and issue with no accept: skid moves to main, and in_ready returns to 1 next cycle.
  - Skid full and issue with simultaneous accept cannot occur, because in_ready=0 while skid is full.
- Ordering is strictly FIFO; no entry is lost or duplicated under any out_ready pattern.
- flush has priority over all handshakes that cycle: main_valid and skid_valid clear next cycle, and any same-cycle accept is discarded. After a flush, in_ready=1 and out_valid=0.
- Reset asserted mid-transfer discards all entries immediately.
- Payload registers load only on load events; a stalled entry holds all outputs stable while out_valid && !out_ready.

Test Plan:
- ADDU $3,$1,$2: in_instr=0x00221821, rs=5, rt=7, out_ready=1 -> next cycle alu_control=12'h001, src1=5, src2=7, dest=3, dest_wen=1, illegal=0.
- SRA $4,$5,3: 0x000520C3, rt_value=0x80000000 -> alu_control=12'h400, src1=0x80000000, src2=3, dest=4. Also LUI $6,0x1234: 0x3C061234 -> 12'h800, src2=0x12340000, dest=6.
- Immediate extension: ADDI 0x2021FFFF -> src2=0xFFFFFFFF, control 12'h001. ANDI 0x3021FFFF -> src2=0x0000FFFF, control 12'h010.
- Backpressure: stream 4 instructions with out_ready=0 -> 2 accepted, then in_ready=0. Raise out_ready -> all 4 are issued in order with no gaps once flowing, and outputs stay stable during the stall.
- Illegal opcode 0xFC000000 and nop 0x00000000 -> illegal=1 with control=0 and dest_wen=0; for nop, illegal=0, control=12'h100, dest_wen=0.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0 and in_ready=1, and the flushed-cycle input is never issued. Async reset mid-stall clears out_valid within the same cycle.

Source files
------------

// File: rtl/alu_issue_stage.sv
// MIPS decode/issue stage feeding the EX-stage ALU.
// A two-entry skid buffer keeps in_ready free of any path from out_ready.
module alu_issue_stage #(
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs_value,
  input  logic [31:0]      in_rt_value,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      alu_control,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  output logic [4:0]       dest,
  output logic             dest_wen,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [11:0] C_ADD  = 12'h001;
  localparam logic [11:0] C_SUB  = 12'h002;
  localparam logic [11:0] C_SLT  = 12'h004;
  localparam logic [11:0] C_SLTU = 12'h008;
  localparam logic [11:0] C_AND  = 12'h010;
  localparam logic [11:0] C_NOR  = 12'h020;
  localparam logic [11:0] C_OR   = 12'h040;
  localparam logic [11:0] C_XOR  = 12'h080;
  localparam logic [11:0] C_SLL  = 12'h100;
  localparam logic [11:0] C_SRL  = 12'h200;
  localparam logic [11:0] C_SRA  = 12'h400;
  localparam logic [11:0] C_LUI  = 12'h800;

  typedef struct packed {
    logic [11:0]      ctrl;
    logic [31:0]      src1;
    logic [31:0]      src2;
    logic [4:0]       dest;
    logic             wen;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [15:0] imm;
  logic [31:0] sext;
  logic [31:0] zext;

  assign op    = in_instr[31:26];
  assign rt    = in_instr[20:16];
  assign rd    = in_instr[15:11];
  assign sa    = in_instr[10:6];
  assign funct = in_instr[5:0];
  assign imm   = in_instr[15:0];
  assign sext  = {{16{imm[15]}}, imm};
  assign zext  = {16'h0000, imm};

  entry_t dec;
  logic   legal;

  always_comb begin
    dec      = '0;
    dec.tag  = in_tag;
    legal    = 1'b1;
    dec.src1 = in_rs_value;
    dec.dest = rt;
    unique case (op)
      6'h00: begin
        dec.dest = rd;
        dec.src2 = in_rt_value;
        unique case (funct)
          6'h20, 6'h21: dec.ctrl = C_ADD;
          6'h22, 6'h23: dec.ctrl = C_SUB;
          6'h2A: dec.ctrl = C_SLT;
          6'h2B: dec.ctrl = C_SLTU;
          6'h24: dec.ctrl = C_AND;
          6'h27: dec.ctrl = C_NOR;
          6'h25: dec.ctrl = C_OR;
          6'h26: dec.ctrl = C_XOR;
          6'h00, 6'h02, 6'h03: begin
            dec.src1 = in_rt_value;
            dec.src2 = {27'b0, sa};
            dec.ctrl = (funct[1:0] == 2'b00) ? C_SLL :
                       (funct[1:0] == 2'b10) ? C_SRL : C_SRA;
          end
          6'h04, 6'h06, 6'h07: begin
            dec.src1 = in_rt_value;
            dec.src2 = in_rs_value;
            dec.ctrl = (funct[1:0] == 2'b00) ? C_SLL :
                       (funct[1:0] == 2'b10) ? C_SRL : C_SRA;
          end
          default: legal = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin
        dec.ctrl = C_ADD;
        dec.src2 = sext;
      end
      6'h0A: begin
        dec.ctrl = C_SLT;
        dec.src2 = sext;
      end
      6'h0B: begin
        dec.ctrl = C_SLTU;
        dec.src2 = sext;
      end
      6'h0C: begin
        dec.ctrl = C_AND;
        dec.src2 = zext;
      end
      6'h0D: begin
        dec.ctrl = C_OR;
        dec.src2 = zext;
      end
      6'h0E: begin
        dec.ctrl = C_XOR;
        dec.src2 = zext;
      end
      6'h0F: begin
        dec.ctrl = C_LUI;
        dec.src1 = '0;
        dec.src2 = {imm, 16'h0000};
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.ctrl = '0;
      dec.src1 = '0;
      dec.src2 = '0;
      dec.dest = '0;
    end
    dec.ill = ~legal;
    dec.wen = legal && (dec.dest != 5'd0);
  end

  entry_t main_q;
  entry_t skid_q;
  logic   main_valid;
  logic   skid_valid;
  logic   accept;
  logic   issue;

  assign in_ready = ~skid_valid;
  assign accept   = in_valid && in_ready && !flush;
  assign issue    = main_valid && out_ready;

  // Valid flags: flush wins over every handshake in its cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || issue) begin
      main_valid <= skid_valid || accept;
      skid_valid <= 1'b0;
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  // Payload only moves on load events so a stalled entry stays stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      if (!main_valid || issue) begin
        if (skid_valid) begin
          main_q <= skid_q;
        end else if (accept) begin
          main_q <= dec;
        end
      end else if (accept) begin
        skid_q <= dec;
      end
    end
  end

  assign out_valid   = main_valid;
  assign alu_control = main_q.ctrl;
  assign alu_src1    = main_q.src1;
  assign alu_src2    = main_q.src2;
  assign dest        = main_q.dest;
  assign dest_wen    = main_q.wen;
  assign illegal     = main_q.ill;
  assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: driver pushes expected entries,
// a negedge monitor compares whatever the DUT presents.
module tb_alu_issue_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_value;
  logic [31:0] in_rt_value;
  logic [31:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] alu_control;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [4:0]  dest;
  logic        dest_wen;
  logic        illegal;
  logic [31:0] out_tag;

  alu_issue_stage #(.TAG_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs_value(in_rs_value),
    .in_rt_value(in_rt_value), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_control(alu_control), .alu_src1(alu_src1),
    .alu_src2(alu_src2), .dest(dest), .dest_wen(dest_wen),
    .illegal(illegal), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] ctrl;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  dest;
    logic        wen;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    exp_t        e;
  } vec_t;

  vec_t vecs[16];
  exp_t q[$];
  int total = 0;
  int bad = 0;
  int n_acc = 0;
  logic [31:0] tag_ctr = 32'h0000_1000;

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] rs,
                              input logic [31:0] rt, input logic [11:0] ctrl,
                              input logic [31:0] s1, input logic [31:0] s2,
                              input logic [4:0] d, input logic w, input logic il);
    vec_t v;
    v.instr = instr;
    v.rs = rs;
    v.rt = rt;
    v.e = '{ctrl: ctrl, s1: s1, s2: s2, dest: d, wen: w, ill: il, tag: '0};
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic send(input int idx);
    int t;
    bit acc;
    exp_t e;
    t = 0;
    acc = 1'b0;
    e = vecs[idx].e;
    e.tag = tag_ctr;
    in_valid = 1'b1;
    in_instr = vecs[idx].instr;
    in_rs_value = vecs[idx].rs;
    in_rt_value = vecs[idx].rt;
    in_tag = tag_ctr;
    while (!acc && t < 50) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        q.push_back(e);
        n_acc++;
      end
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: vector %0d never accepted", idx);
    end
    tag_ctr = tag_ctr + 32'd4;
    in_valid = 1'b0;
  endtask

  // Monitor: every presented entry must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_issue: tag %h ctrl %h", out_tag, alu_control);
      end else begin
        e = q[0];
        if ({alu_control, alu_src1, alu_src2, dest, dest_wen, illegal, out_tag} !== e) begin
          bad++;
          $display("FAIL issue_tag%h: got ctrl=%h s1=%h s2=%h d=%0d w=%b il=%b tag=%h want ctrl=%h s1=%h s2=%h d=%0d w=%b il=%b tag=%h",
                   e.tag, alu_control, alu_src1, alu_src2, dest, dest_wen, illegal, out_tag,
                   e.ctrl, e.s1, e.s2, e.dest, e.wen, e.ill, e.tag);
        end
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic drain(input string name);
    int t;
    t = 0;
    while (q.size() > 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk(name, 64'(q.size()), 64'd0);
  endtask

  initial begin
    vecs[0]  = mk(32'h00221821, 32'd5, 32'd7, 12'h001, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
    vecs[1]  = mk(32'h000520C3, 32'd9, 32'h80000000, 12'h400, 32'h80000000, 32'd3, 5'd4, 1'b1, 1'b0);
    vecs[2]  = mk(32'h3C061234, 32'h11, 32'h22, 12'h800, 32'd0, 32'h12340000, 5'd6, 1'b1, 1'b0);
    vecs[3]  = mk(32'h2021FFFF, 32'd10, 32'd1, 12'h001, 32'd10, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0);
    vecs[4]  = mk(32'h3021FFFF, 32'd10, 32'd1, 12'h010, 32'd10, 32'h0000FFFF, 5'd1, 1'b1, 1'b0);
    vecs[5]  = mk(32'hFC000000, 32'd3, 32'd4, 12'h000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    vecs[6]  = mk(32'h00000000, 32'd3, 32'h55, 12'h100, 32'h55, 32'd0, 5'd0, 1'b0, 1'b0);
    vecs[7]  = mk(32'h00A62004, 32'h23, 32'hF0, 12'h100, 32'hF0, 32'h23, 5'd4, 1'b1, 1'b0);
    vecs[8]  = mk(32'h01093823, 32'd50, 32'd8, 12'h002, 32'd50, 32'd8, 5'd7, 1'b1, 1'b0);
    vecs[9]  = mk(32'h2C228000, 32'h77, 32'd0, 12'h008, 32'h77, 32'hFFFF8000, 5'd2, 1'b1, 1'b0);
    vecs[10] = mk(32'h00225027, 32'hA, 32'hB, 12'h020, 32'hA, 32'hB, 5'd10, 1'b1, 1'b0);
    vecs[11] = mk(32'h3443ABCD, 32'h1, 32'h2, 12'h040, 32'h1, 32'h0000ABCD, 5'd3, 1'b1, 1'b0);
    vecs[12] = mk(32'h386400FF, 32'h5, 32'h6, 12'h080, 32'h5, 32'h000000FF, 5'd4, 1'b1, 1'b0);
    vecs[13] = mk(32'h00041142, 32'h9, 32'hFF00, 12'h200, 32'hFF00, 32'd5, 5'd2, 1'b1, 1'b0);
    vecs[14] = mk(32'h0043082A, 32'hC, 32'hD, 12'h004, 32'hC, 32'hD, 5'd1, 1'b1, 1'b0);
    vecs[15] = mk(32'h00000001, 32'hC, 32'hD, 12'h000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);

    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_rs_value = '0;
    in_rt_value = '0;
    in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_payload", 64'({alu_control, alu_src1, dest, dest_wen, illegal}), 64'd0);
    chk("reset_src2_tag", 64'({alu_src2, out_tag}), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Streaming, every decode pattern back to back.
    for (int i = 0; i < 16; i++) send(i);
    drain("stream_drain");

    // Backpressure: only two fit while EX stalls.
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(i + 7);
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_accepted", 64'(n_acc), 64'd2);
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Flush with both entries full and a pending input.
    out_ready = 1'b0;
    send(0);
    send(1);
    chk("pre_flush_full", 64'({out_valid, in_ready}), 64'b10);
    in_valid = 1'b1;
    in_instr = vecs[2].instr;
    in_rs_value = vecs[2].rs;
    in_rt_value = vecs[2].rt;
    in_tag = 32'hDEAD_0000;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(3);
    drain("post_flush_drain");

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    send(4);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    send(5);
    send(6);
    drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
